sc_mul_scheduler: RTL and testbench

Sequencing and arbitration controller for the shared stochastic serial multiplier datapath (two SNGs, AND gate, stochastic-to-binary counter). It accepts operand pairs from up to NUM_REQ requesters and grants them round-robin. For each granted operation it clears the datapath, enables it for one full bitstream, and captures the counter result once the SNG overflow (done) fires. The result is returned to the requester with a valid/ready handshake.

---
 rtl/sc_mul_scheduler_pkg.sv | 22 ++
 rtl/sc_mul_scheduler_if.sv | 41 ++++
 rtl/sc_mul_scheduler_rr_arb.sv | 34 +++
 rtl/sc_mul_scheduler.sv | 141 ++++++++++++++
 tb/tb_sc_mul_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sc_mul_scheduler_pkg.sv
// Shared types and defaults for the stochastic multiplier scheduler.
package sc_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_CAPTURE,
      ST_RESP
   } sched_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_IN_WIDTH    = 8;
   localparam int DEF_OUT_WIDTH   = 8;
   localparam int DEF_TIMEOUT_CYC = 260;

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sc_mul_scheduler_if.sv
// Requester, response and datapath-control bundle of the scheduler.
// slave: scheduler side; master: requesters, consumer and datapath side.
interface sc_mul_scheduler_if
   import sc_sched_pkg::*;
#(
   parameter int NUM_REQ   = DEF_NUM_REQ,
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH
) ();
   localparam int ID_W = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*IN_WIDTH-1:0] req_a;
   logic [NUM_REQ*IN_WIDTH-1:0] req_b;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [ID_W-1:0]             rsp_id;
   logic [OUT_WIDTH-1:0]        rsp_data;
   logic                        rsp_err;
   logic                        busy;
   logic                        mul_clr;
   logic                        mul_en;
   logic [IN_WIDTH-1:0]         mul_a;
   logic [IN_WIDTH-1:0]         mul_b;
   logic [OUT_WIDTH-1:0]        mul_result;
   logic                        mul_done;

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
             mul_clr, mul_en, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
             mul_clr, mul_en, mul_a, mul_b
   );

endinterface

// File: rtl/sc_mul_scheduler_rr_arb.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr.
module sc_rr_arb
   import sc_sched_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_idx,
   output logic               any_req
);

   int j;

   // Scan farthest-first so the nearest requester after rr_ptr overwrites last.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any_req = 1'b0;
      j       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         j = (int'(rr_ptr) + k) % NUM_REQ;
         if (req[j]) begin
            gnt     = '0;
            gnt[j]  = 1'b1;
            gnt_idx = ID_W'(j);
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sc_mul_scheduler.sv
// Round-robin sequencer for the shared stochastic multiplier datapath.
// Optional RUN watchdog enabled by defining SC_MUL_TIMEOUT_EN.
module sc_mul_scheduler
   import sc_sched_pkg::*;
#(
   parameter int NUM_REQ     = DEF_NUM_REQ,
   parameter int IN_WIDTH    = DEF_IN_WIDTH,
   parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input logic            clk,
   input logic            rst,
   sc_mul_scheduler_if.slave bus
);

   localparam int ID_W = idx_w(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_chk
      $error("sc_mul_scheduler: parameter out of range");
   end

   sched_state_t          state_q, state_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic [IN_WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [OUT_WIDTH-1:0]  data_q, data_d;
   logic                  err_q, err_d;

   logic [NUM_REQ-1:0]    gnt;
   logic [ID_W-1:0]       gnt_idx;
   logic                  any_req;

   sc_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .req     (bus.req_valid),
      .rr_ptr  (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any_req (any_req)
   );

`ifdef SC_MUL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic             tmo_q, tmo_d, tmo_hit;

   assign tmo_hit = (run_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      run_cnt_d = run_cnt_q;
      tmo_d     = tmo_q;
      if (state_q == ST_LOAD) begin
         run_cnt_d = '0;
         tmo_d     = 1'b0;
      end else if (state_q == ST_RUN && !bus.mul_done) begin
         run_cnt_d = run_cnt_q + 1'b1;
         if (tmo_hit) tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         tmo_q     <= tmo_d;
      end
   end
`else
   logic tmo_q, tmo_hit;
   assign tmo_q   = 1'b0;
   assign tmo_hit = 1'b0;
`endif

   // In IDLE the arbiter's grant is req_ready, so any_req means a handshake.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      a_d      = a_q;
      b_d      = b_q;
      data_d   = data_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               id_d     = gnt_idx;
               a_d      = bus.req_a[int'(gnt_idx)*IN_WIDTH +: IN_WIDTH];
               b_d      = bus.req_b[int'(gnt_idx)*IN_WIDTH +: IN_WIDTH];
               rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_RUN;
         ST_RUN: begin
            if (bus.mul_done || tmo_hit) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            data_d  = tmo_q ? '0 : bus.mul_result;
            err_d   = tmo_q;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE && !rst) ? gnt : '0;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.mul_clr   = (state_q == ST_LOAD);
   assign bus.mul_en    = (state_q == ST_RUN);
   assign bus.rsp_valid = (state_q == ST_RESP);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_data  = data_q;
   assign bus.rsp_err   = err_q;
   assign bus.mul_a     = a_q;
   assign bus.mul_b     = b_q;

endmodule

// File: tb/tb_sc_mul_scheduler.sv
// Randomized bench for sc_mul_scheduler with a 256-cycle datapath stub.
// Watchdog scenario runs only when SC_MUL_TIMEOUT_EN is defined.
module tb_sc_mul_scheduler;
   import sc_sched_pkg::*;

   localparam int NR = 4, IW = 8, OW = 8, TMO = 260, STREAM = 256;
   localparam int LAT = 3 + STREAM;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0, n_clr = 0;
   int   n_chk = 0, n_pass = 0;
   int   ptr_m = 0;
   int   stub_cnt = 0;
   bit   stub_hang = 1'b0, force_done = 1'b0, done_in_load = 1'b0;
   logic [IW-1:0] opa [NR];
   logic [IW-1:0] opb [NR];

   sc_mul_scheduler_if #(.NUM_REQ(NR), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

   sc_mul_scheduler #(.NUM_REQ(NR), .IN_WIDTH(IW), .OUT_WIDTH(OW), .TIMEOUT_CYC(TMO)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.mul_clr) n_clr <= n_clr + 1;
      if (bus.mul_clr) stub_cnt <= 0;
      else if (bus.mul_en) stub_cnt <= stub_cnt + 1;
   end

   // Datapath stub: done in the 256th enabled cycle, result = a*b/256.
   assign bus.mul_done   = (bus.mul_en && stub_cnt == STREAM - 1 && !stub_hang) || force_done;
   assign bus.mul_result = OW'((int'(bus.mul_a) * int'(bus.mul_b)) >> 8);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   function automatic int pick(input logic [NR-1:0] m);
      for (int k = 0; k < NR; k++)
         if (m[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
      return 0;
   endfunction

   function automatic int prod(input int a, input int b);
      return (a * b) / 256;
   endfunction

   task automatic chk_zero(input string tag);
      chk({tag, "_req_ready"}, 32'(bus.req_ready), 0);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
      chk({tag, "_rsp_id"},    32'(bus.rsp_id), 0);
      chk({tag, "_rsp_data"},  32'(bus.rsp_data), 0);
      chk({tag, "_rsp_err"},   32'(bus.rsp_err), 0);
      chk({tag, "_busy"},      32'(bus.busy), 0);
      chk({tag, "_mul_clr"},   32'(bus.mul_clr), 0);
      chk({tag, "_mul_en"},    32'(bus.mul_en), 0);
      chk({tag, "_mul_a"},     32'(bus.mul_a), 0);
      chk({tag, "_mul_b"},     32'(bus.mul_b), 0);
   endtask

   task automatic drive_ops();
      for (int i = 0; i < NR; i++) begin
         bus.req_a[i*IW +: IW] = opa[i];
         bus.req_b[i*IW +: IW] = opb[i];
      end
   endtask

   // Called at a negedge. rdy_dly<0: caller holds rsp_ready high throughout.
   task automatic op(input logic [NR-1:0] mask, input bit keep, input int rdy_dly,
                     input int exp_lat, input bit exp_err, output int w, output int gc, output int hs);
      int tmo, ed;
      drive_ops();
      bus.req_valid = mask;
      if (rdy_dly >= 0) bus.rsp_ready = 1'b0;
      w = pick(mask);
      ed = exp_err ? 0 : prod(int'(opa[w]), int'(opb[w]));
      #1;
      tmo = 0;
      while (bus.req_ready == '0 && tmo < 20) begin
         @(negedge clk); #1; tmo++;
      end
      chk("grant", 32'(bus.req_ready), 32'(1) << w);
      gc = cyc;
      ptr_m = (w + 1) % NR;
      @(negedge clk);
      if (!keep) bus.req_valid = '0;
      chk("load_clr", 32'(bus.mul_clr), 1);
      if (done_in_load) begin
         force_done = 1'b1;
         @(posedge clk); #1;
         force_done = 1'b0;
      end
      tmo = 0;
      while (!bus.rsp_valid && tmo < 400) begin
         @(negedge clk); tmo++;
      end
      chk("latency", 32'(cyc - gc), 32'(exp_lat));
      chk("rsp_id", 32'(bus.rsp_id), 32'(w));
      chk("rsp_data", 32'(bus.rsp_data), 32'(ed));
      chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      for (int i = 0; i < rdy_dly; i++) begin
         bus.req_valid = '1;
         @(negedge clk);
         chk("hold_valid", 32'(bus.rsp_valid), 1);
         chk("hold_data", 32'(bus.rsp_data), 32'(ed));
         chk("hold_id", 32'(bus.rsp_id), 32'(w));
         chk("hold_req_ready", 32'(bus.req_ready), 0);
      end
      if (rdy_dly > 0) bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      hs = cyc;
      @(negedge clk);
      chk("rsp_pulse", 32'(bus.rsp_valid), 0);
      if (rdy_dly >= 0) bus.rsp_ready = 1'b0;
   endtask

   initial begin
      int w, gc, hs, prev_hs, tmo;
      int order [5] = '{0, 1, 2, 3, 0};
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("rst");
      rst = 1'b0;
      @(negedge clk);
      chk_zero("idle");

      // All requesters continuously valid, consumer always ready.
      for (int i = 0; i < NR; i++) begin
         opa[i] = IW'(64 * i + $urandom_range(1, 63));
         opb[i] = IW'($urandom_range(0, 255));
      end
      bus.rsp_ready = 1'b1;
      prev_hs = 0;
      for (int k = 0; k < 5; k++) begin
         op('1, 1'b1, -1, LAT, 1'b0, w, gc, hs);
         chk("rr_order", 32'(w), 32'(order[k]));
         if (k > 0) chk("b2b_grant", 32'(gc - prev_hs), 1);
         prev_hs = hs;
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      @(negedge clk);

      // Single request from requester 2.
      opa[2] = 8'd128;
      opb[2] = 8'd128;
      begin
         int c0;
         c0 = n_clr;
         op(4'b0100, 1'b0, 0, LAT, 1'b0, w, gc, hs);
         chk("single_clr_once", 32'(n_clr - c0), 1);
         chk("single_data_64", 32'(bus.rsp_data), 64);
      end

      // Consumer stalls 10 cycles in RESP.
      opa[1] = IW'($urandom);
      opb[1] = IW'($urandom);
      op(4'b0010, 1'b0, 10, LAT, 1'b0, w, gc, hs);

      // Stray done pulses in IDLE and LOAD.
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      chk("idle_done_busy", 32'(bus.busy), 0);
      chk("idle_done_rsp", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      chk("idle_done_busy2", 32'(bus.busy), 0);
      opa[3] = IW'($urandom);
      opb[3] = IW'($urandom);
      done_in_load = 1'b1;
      op(4'b1000, 1'b0, 0, LAT, 1'b0, w, gc, hs);
      done_in_load = 1'b0;

      // Reset mid-RUN after granting requester 2; pointer must restart at 0.
      opa[2] = IW'($urandom);
      opb[2] = IW'($urandom);
      drive_ops();
      bus.req_valid = 4'b0100;
      #1;
      tmo = 0;
      while (bus.req_ready == '0 && tmo < 20) begin
         @(negedge clk); #1; tmo++;
      end
      chk("rst_pre_grant", 32'(bus.req_ready), 32'h4);
      @(negedge clk);
      bus.req_valid = '0;
      repeat (99) @(negedge clk);
      chk("rst_pre_run", 32'(bus.mul_en), 1);
      rst = 1'b1;
      #1;
      chk_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      ptr_m = 0;
      @(negedge clk);
      opa[1] = IW'($urandom);
      opb[1] = IW'($urandom);
      opa[3] = IW'($urandom);
      opb[3] = IW'($urandom);
      op(4'b1010, 1'b0, 0, LAT, 1'b0, w, gc, hs);
      chk("post_rst_winner", 32'(w), 1);

      // Random masks, operands and consumer delays.
      for (int n = 0; n < 6; n++) begin
         for (int i = 0; i < NR; i++) begin
            opa[i] = IW'($urandom);
            opb[i] = IW'($urandom);
         end
         op(NR'($urandom_range(1, 15)), 1'b0, $urandom_range(0, 3), LAT, 1'b0, w, gc, hs);
      end

`ifdef SC_MUL_TIMEOUT_EN
      stub_hang = 1'b1;
      op(4'b0001, 1'b0, 0, 3 + TMO, 1'b1, w, gc, hs);
      stub_hang = 1'b0;
      opa[2] = IW'($urandom);
      opb[2] = IW'($urandom);
      op(4'b0100, 1'b0, 0, LAT, 1'b0, w, gc, hs);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
